noc_pkt_rx: RTL and testbench

Ejection-side packet receiver for the NoC. It accepts a stream of head/body/tail flits from a router's local output port and checks that the destination field matches this node. It reassembles the data flits into one wide packet word and hands the packet to the core through a valid/ready interface. It is the receiving end of the flit protocol generated by the injection side; misrouted, oversized and malformed packets are dropped and flagged.

---
 rtl/noc_pkt_rx.sv | 124 ++++++++++++
 tb/tb_noc_pkt_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pkt_rx.sv
// NoC ejection-port receiver: checks the head destination, reassembles data
// flits into one wide word and hands it to the core over valid/ready.
module noc_pkt_rx #(
    parameter int FLIT_W    = 32,
    parameter int MAX_FLITS = 4,
    parameter int ID_W      = 4,
    parameter int MY_ID     = 0,
    localparam int LEN_W    = $clog2(MAX_FLITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flit_valid,
    input  logic [1:0]                  flit_type,
    input  logic [FLIT_W-1:0]           flit_data,
    output logic                        flit_ready,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [MAX_FLITS*FLIT_W-1:0] pkt_data,
    output logic [LEN_W-1:0]            pkt_len,
    output logic [ID_W-1:0]             pkt_src,
    output logic                        err_misroute,
    output logic                        err_overflow,
    output logic                        err_proto
);

    typedef enum logic [1:0] {
        IDLE, COLLECT, DROP, DELIVER
    } state_e;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FLITS);

    state_e                      state_q, state_d;
    logic [MAX_FLITS*FLIT_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [ID_W-1:0]             src_q, src_d;
    logic                        mis_q, mis_d;
    logic                        ovf_q, ovf_d;
    logic                        proto_q, proto_d;

    logic is_head, is_tail, dest_ok;

    assign is_head = (flit_type == T_HEAD) || (flit_type == T_HT);
    assign is_tail = (flit_type == T_TAIL);
    assign dest_ok = (flit_data[ID_W-1:0] == ID_W'(MY_ID));

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        src_d   = src_q;
        mis_d   = 1'b0;
        ovf_d   = 1'b0;
        proto_d = 1'b0;
        if (state_q == DELIVER) begin
            if (pkt_ready) state_d = IDLE;
        end else if (flit_valid) begin
            if (is_head) begin
                // A head always restarts reception, abandoning any open packet
                proto_d = (state_q != IDLE);
                if (dest_ok) begin
                    data_d  = '0;
                    len_d   = '0;
                    src_d   = flit_data[2*ID_W-1:ID_W];
                    state_d = (flit_type == T_HT) ? DELIVER : COLLECT;
                end else begin
                    mis_d   = 1'b1;
                    state_d = (flit_type == T_HT) ? IDLE : DROP;
                end
            end else begin
                unique case (state_q)
                    IDLE: proto_d = 1'b1;
                    COLLECT: begin
                        if (len_q < LEN_MAX) begin
                            for (int k = 0; k < MAX_FLITS; k++) begin
                                if (LEN_W'(k) == len_q)
                                    data_d[k*FLIT_W +: FLIT_W] = flit_data;
                            end
                            len_d = len_q + 1'b1;
                            if (is_tail) state_d = DELIVER;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = is_tail ? IDLE : DROP;
                        end
                    end
                    DROP: if (is_tail) state_d = IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            src_q   <= '0;
            mis_q   <= 1'b0;
            ovf_q   <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            src_q   <= src_d;
            mis_q   <= mis_d;
            ovf_q   <= ovf_d;
            proto_q <= proto_d;
        end
    end

    assign flit_ready   = (state_q != DELIVER);
    assign pkt_valid    = (state_q == DELIVER);
    assign pkt_data     = data_q;
    assign pkt_len      = len_q;
    assign pkt_src      = src_q;
    assign err_misroute = mis_q;
    assign err_overflow = ovf_q;
    assign err_proto    = proto_q;

endmodule

// File: tb/tb_noc_pkt_rx.sv
// Bench for noc_pkt_rx: flit vector table with a packet scoreboard plus
// hand-written latency, stall and reset sequences.
module tb_noc_pkt_rx;

    localparam int FW = 32;
    localparam int MF = 4;
    localparam int IW = 4;
    localparam int LW = $clog2(MF + 1);

    localparam logic [1:0] H  = 2'b00;
    localparam logic [1:0] B  = 2'b01;
    localparam logic [1:0] T  = 2'b10;
    localparam logic [1:0] HT = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flit_valid;
    logic [1:0]        flit_type;
    logic [FW-1:0]     flit_data;
    logic              flit_ready;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [MF*FW-1:0]  pkt_data;
    logic [LW-1:0]     pkt_len;
    logic [IW-1:0]     pkt_src;
    logic              err_misroute;
    logic              err_overflow;
    logic              err_proto;

    noc_pkt_rx #(.FLIT_W(FW), .MAX_FLITS(MF), .ID_W(IW), .MY_ID(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .flit_valid(flit_valid), .flit_type(flit_type),
        .flit_data(flit_data), .flit_ready(flit_ready),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_data(pkt_data), .pkt_len(pkt_len), .pkt_src(pkt_src),
        .err_misroute(err_misroute), .err_overflow(err_overflow),
        .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0]    len;
        logic [IW-1:0]    src;
        logic [MF*FW-1:0] data;
    } pkt_t;

    typedef struct {
        logic [1:0]  t;
        logic [FW-1:0] d;
        logic [2:0]  err;   // {proto, misroute, overflow}
        bit          push;
        pkt_t        pkt;
    } vec_t;

    pkt_t exp_q[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [MF*FW-1:0] act,
                       input logic [MF*FW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] hd(input int dest, input int src);
        return FW'((src << IW) | dest);
    endfunction

    function automatic pkt_t mkp(input int len, input int src,
                                 input logic [FW-1:0] w0, input logic [FW-1:0] w1,
                                 input logic [FW-1:0] w2, input logic [FW-1:0] w3);
        pkt_t p;
        p.len  = LW'(len);
        p.src  = IW'(src);
        p.data = {w3, w2, w1, w0};
        return p;
    endfunction

    task automatic add(input logic [1:0] t, input logic [FW-1:0] d,
                       input logic [2:0] err);
        vec_t v;
        v.t = t; v.d = d; v.err = err; v.push = 1'b0;
        v.pkt = mkp(0, 0, 0, 0, 0, 0);
        vecs.push_back(v);
    endtask

    task automatic addp(input logic [1:0] t, input logic [FW-1:0] d,
                        input logic [2:0] err, input pkt_t p);
        vec_t v;
        v.t = t; v.d = d; v.err = err; v.push = 1'b1; v.pkt = p;
        vecs.push_back(v);
    endtask

    // Called at #1 after a clock edge; returns at #1 after the accepting edge.
    task automatic flit(input logic [1:0] t, input logic [FW-1:0] d,
                        input logic [2:0] err, input string name);
        int waited = 0;
        flit_valid = 1'b1;
        flit_type  = t;
        flit_data  = d;
        while (!flit_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!flit_ready) chk({name, "_ready_timeout"}, 0, 1);
        @(posedge clk); #1;
        flit_valid = 1'b0;
        chk({name, "_err"}, {err_proto, err_misroute, err_overflow}, err);
    endtask

    // Packet handshake happens at the next posedge; inputs only move at #1.
    always @(negedge clk) begin
        if (rst_n && pkt_valid && pkt_ready) begin
            pkt_t e;
            if (exp_q.size() == 0) begin
                chk("unexpected_pkt", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pkt_len",  pkt_len,  e.len);
                chk("pkt_src",  pkt_src,  e.src);
                chk("pkt_data", pkt_data, e.data);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        flit_valid = 1'b0;
        flit_type  = H;
        flit_data  = '0;
        pkt_ready  = 1'b1;

        // Misrouted packet, then a good one
        add(H, hd(7, 1), 3'b010);
        add(B, 32'h1, 3'b000);
        add(B, 32'h2, 3'b000);
        add(T, 32'h3, 3'b000);
        add(H, hd(3, 4), 3'b000);
        add(B, 32'h11, 3'b000);
        addp(T, 32'h22, 3'b000, mkp(2, 4, 32'h11, 32'h22, 0, 0));
        // Overflow on tail, then IDLE shown by proto on a lone body
        add(H, hd(3, 6), 3'b000);
        add(B, 32'h1, 3'b000);
        add(B, 32'h2, 3'b000);
        add(B, 32'h3, 3'b000);
        add(B, 32'h4, 3'b000);
        add(T, 32'h5, 3'b001);
        add(B, 32'h7, 3'b100);
        // New head inside an open packet
        add(H, hd(3, 1), 3'b000);
        add(B, 32'h1, 3'b000);
        add(H, hd(3, 2), 3'b100);
        add(B, 32'h9, 3'b000);
        addp(T, 32'h8, 3'b000, mkp(2, 2, 32'h9, 32'h8, 0, 0));
        // Bad-dest heads inside DROP raise both errors
        add(H, hd(7, 1), 3'b010);
        add(B, 32'h5, 3'b000);
        add(H, hd(9, 1), 3'b110);
        add(HT, hd(7, 2), 3'b110);
        addp(HT, hd(3, 1), 3'b000, mkp(0, 1, 0, 0, 0, 0));
        add(T, 32'h6, 3'b100);
        // Overflow on a body goes to DROP; tail closes it silently
        add(H, hd(3, 5), 3'b000);
        add(B, 32'h1, 3'b000);
        add(B, 32'h2, 3'b000);
        add(B, 32'h3, 3'b000);
        add(B, 32'h4, 3'b000);
        add(B, 32'h5, 3'b001);
        add(B, 32'h6, 3'b000);
        add(T, 32'h7, 3'b000);
        addp(HT, hd(3, 7), 3'b000, mkp(0, 7, 0, 0, 0, 0));
        // Full-length packet
        add(H, hd(3, 2), 3'b000);
        add(B, 32'hA1, 3'b000);
        add(B, 32'hA2, 3'b000);
        add(B, 32'hA3, 3'b000);
        addp(T, 32'hA4, 3'b000, mkp(4, 2, 32'hA1, 32'hA2, 32'hA3, 32'hA4));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_flit_ready", flit_ready, 1);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_errs", {err_proto, err_misroute, err_overflow}, 0);
        chk("rst_len_src_data", {pkt_len, pkt_src, pkt_data}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic packet with latency and flit_ready check
        flit(H, hd(3, 5), 3'b000, "t1_head");
        flit(B, 32'hA, 3'b000, "t1_b0");
        flit(B, 32'hB, 3'b000, "t1_b1");
        exp_q.push_back(mkp(3, 5, 32'hA, 32'hB, 32'hC, 0));
        flit(T, 32'hC, 3'b000, "t1_tail");
        chk("t1_pkt_valid", pkt_valid, 1);
        chk("t1_flit_ready", flit_ready, 0);
        @(posedge clk); #1;
        chk("t1_valid_drop", pkt_valid, 0);
        chk("t1_ready_back", flit_ready, 1);

        // Zero-length packet held by backpressure
        pkt_ready = 1'b0;
        exp_q.push_back(mkp(0, 1, 0, 0, 0, 0));
        flit(HT, hd(3, 1), 3'b000, "t2_ht");
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", pkt_valid, 1);
            chk("t2_hold_ready", flit_ready, 0);
            chk("t2_hold_out", {pkt_len, pkt_src, pkt_data},
                {LW'(0), IW'(1), {MF*FW{1'b0}}});
            @(posedge clk); #1;
        end
        pkt_ready = 1'b1;
        @(posedge clk); #1;
        chk("t2_release_valid", pkt_valid, 0);
        chk("t2_release_ready", flit_ready, 1);

        foreach (vecs[i]) begin
            if (vecs[i].push) exp_q.push_back(vecs[i].pkt);
            flit(vecs[i].t, vecs[i].d, vecs[i].err, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-packet
        flit(H, hd(3, 1), 3'b000, "t6_head");
        flit(B, 32'h5, 3'b000, "t6_body");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_data", pkt_data, 0);
        chk("t6_rst_len", pkt_len, 0);
        chk("t6_rst_ready", flit_ready, 1);
        chk("t6_rst_errs", {err_proto, err_misroute, err_overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        flit(H, hd(3, 2), 3'b000, "t6_head2");
        exp_q.push_back(mkp(1, 2, 32'h33, 0, 0, 0));
        flit(T, 32'h33, 3'b000, "t6_tail");
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
